apb_master: RTL and testbench

Single-outstanding APB3 requester that converts a valid/ready command interface into APB SETUP/ACCESS transfers and returns one response per command. It sits between the processor/bus bridge and the APB register slaves, driving the shared PADDR/PWRITE/PWDATA/PENABLE bus and a decoded one-hot PSEL per slave. It also enforces a PREADY timeout so a dead slave cannot hang the requester.

---
 rtl/apb_pkg.sv | 14 +
 rtl/apb_master_if.sv | 45 ++++
 rtl/apb_sel_decode.sv | 19 +
 rtl/apb_master.sv | 111 +++++++++++
 tb/tb_apb_master.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB requester slice.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

    localparam int APB_ADDR_W  = 32;
    localparam int APB_DATA_W  = 32;
    localparam int APB_NUM_SLV = 4;

endpackage

// File: rtl/apb_master_if.sv
// Command/response handshake plus the shared APB bus with per-slave return lanes.
interface apb_master_if
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int NUM_SLV = APB_NUM_SLV
);

    logic                        cmd_valid;
    logic                        cmd_ready;
    logic                        cmd_write;
    logic [ADDR_W-1:0]           cmd_addr;
    logic [DATA_W-1:0]           cmd_wdata;

    logic                        rsp_valid;
    logic [DATA_W-1:0]           rsp_rdata;
    logic                        rsp_err;

    logic [NUM_SLV-1:0]          PSEL;
    logic                        PENABLE;
    logic [ADDR_W-1:0]           PADDR;
    logic                        PWRITE;
    logic [DATA_W-1:0]           PWDATA;
    logic [DATA_W*NUM_SLV-1:0]   PRDATA;
    logic [NUM_SLV-1:0]          PREADY;
    logic [NUM_SLV-1:0]          PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_sel_decode.sv
// Slave index to one-hot PSEL, forced to zero outside the SETUP/ACCESS phases.
module apb_sel_decode #(
    parameter  int NUM_SLV = 4,
    localparam int SEL_W   = $clog2(NUM_SLV)
) (
    input  logic [SEL_W-1:0]   idx,
    input  logic               en,
    output logic [NUM_SLV-1:0] sel
);

    always_comb begin
        // NOTE: assign a default before any branch so no path leaves sel unassigned (no latch).
        sel = '0;
        if (en) begin
            sel[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB3 requester: one command in, one SETUP/ACCESS transfer, one response out.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int NUM_SLV = APB_NUM_SLV,
    parameter int SEL_LSB = 12,
    parameter int TIMEOUT = 16
) (
    input  logic         PCLK,
    input  logic         PRESET,
    apb_master_if.master bus
);

    localparam int SEL_W = $clog2(NUM_SLV);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    apb_state_e          state;
    logic [SEL_W-1:0]    sel_idx;
    logic [CNT_W-1:0]    wait_cnt;
    logic                penable;
    logic [ADDR_W-1:0]   paddr;
    logic                pwrite;
    logic [DATA_W-1:0]   pwdata;
    logic                rsp_valid;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                rsp_err;

    logic                pready_sel;
    logic                pslverr_sel;
    logic [DATA_W-1:0]   prdata_sel;

    // Only the addressed slave's return lane is ever looked at.
    assign pready_sel  = bus.PREADY[sel_idx];
    assign pslverr_sel = bus.PSLVERR[sel_idx];
    assign prdata_sel  = bus.PRDATA[int'(sel_idx) * DATA_W +: DATA_W];

    always_ff @(posedge PCLK or posedge PRESET) begin
        // NOTE: non-blocking everywhere here so every branch reads pre-edge state.
        if (PRESET) begin
            state     <= IDLE;
            sel_idx   <= '0;
            wait_cnt  <= '0;
            penable   <= 1'b0;
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        paddr   <= bus.cmd_addr;
                        pwrite  <= bus.cmd_write;
                        pwdata  <= bus.cmd_wdata;
                        sel_idx <= bus.cmd_addr[SEL_LSB +: SEL_W];
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    // First ACCESS cycle is count 1, so TIMEOUT counts ACCESS cycles exactly.
                    penable  <= 1'b1;
                    wait_cnt <= CNT_W'(1);
                    state    <= ACCESS;
                end
                ACCESS: begin
                    if (pready_sel) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= pslverr_sel;
                        rsp_rdata <= (!pwrite && !pslverr_sel) ? prdata_sel : '0;
                        penable   <= 1'b0;
                        wait_cnt  <= '0;
                        state     <= IDLE;
                    end else if (wait_cnt == CNT_W'(TIMEOUT)) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        penable   <= 1'b0;
                        wait_cnt  <= '0;
                        state     <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    apb_sel_decode #(
        .NUM_SLV (NUM_SLV)
    ) u_sel_decode (
        .idx (sel_idx),
        .en  (state != IDLE),
        .sel (bus.PSEL)
    );

    assign bus.cmd_ready = (state == IDLE);
    assign bus.PENABLE   = penable;
    assign bus.PADDR     = paddr;
    assign bus.PWRITE    = pwrite;
    assign bus.PWDATA    = pwdata;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = rsp_rdata;
    assign bus.rsp_err   = rsp_err;

endmodule

// File: tb/tb_apb_master.sv
// Scoreboarded bench for apb_master: behavioural slaves, protocol monitor, per-scenario tasks.
module tb_apb_master;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int NS      = 4;
    localparam int SEL_LSB = 12;
    localparam int TO      = 16;

    logic PCLK   = 1'b0;
    logic PRESET = 1'b1;

    always #5 PCLK = ~PCLK;

    apb_master_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS)) bus ();

    apb_master #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .NUM_SLV (NS),
        .SEL_LSB (SEL_LSB),
        .TIMEOUT (TO)
    ) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    typedef struct {
        logic          err;
        logic [DW-1:0] rdata;
    } rsp_t;

    rsp_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    int cyc          = 0;
    int acc_cycles   = 0;
    int rsp_count    = 0;
    int last_rsp_cyc = 0;
    int last_acc_cyc = 0;

    logic [AW-1:0] cur_addr  = '0;
    logic          cur_write = 1'b0;
    logic [DW-1:0] cur_wdata = '0;
    int            cur_idx   = 0;

    int            wait_cfg  [NS];
    logic          err_cfg   [NS];
    logic          early_cfg [NS];
    logic [DW-1:0] rdata_cfg [NS];
    int            acnt      [NS];
    logic [NS-1:0] prev_psel = '0;

    always @(posedge PCLK) cyc++;

    // Behavioural slaves: selected one answers after wait_cfg extra ACCESS cycles,
    // unselected ones assert PREADY/PSLVERR constantly so any leakage shows up.
    always @(negedge PCLK) begin
        for (int i = 0; i < NS; i++) begin
            bus.PRDATA[i*DW +: DW] = rdata_cfg[i];
            if (bus.PSEL[i]) begin
                if (bus.PENABLE) acnt[i]++;
                else             acnt[i] = 0;
                bus.PREADY[i]  = bus.PENABLE ? (acnt[i] > wait_cfg[i]) : early_cfg[i];
                bus.PSLVERR[i] = err_cfg[i];
            end else begin
                acnt[i]        = 0;
                bus.PREADY[i]  = 1'b1;
                bus.PSLVERR[i] = 1'b1;
            end
        end
    end

    // Protocol monitor and response scoreboard.
    always @(negedge PCLK) begin
        logic [NS-1:0] exp_sel;
        logic          exp_en;
        rsp_t          e;
        if (bus.rsp_valid) begin
            n_cmp++;
            last_rsp_cyc = cyc;
            rsp_count++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL rsp_unexpected: rsp_valid=1 err=%b rdata=%h, required no response", bus.rsp_err, bus.rsp_rdata);
            end else begin
                e = exp_q.pop_front();
                if (bus.rsp_err !== e.err || bus.rsp_rdata !== e.rdata) begin
                    n_bad++;
                    $display("FAIL rsp_data: err=%b rdata=%h, required err=%b rdata=%h", bus.rsp_err, bus.rsp_rdata, e.err, e.rdata);
                end
            end
        end
        if (PRESET) begin
            prev_psel = '0;
        end else begin
            n_cmp++;
            if (bus.cmd_ready !== (bus.PSEL == '0)) begin
                n_bad++;
                $display("FAIL cmd_ready_phase: cmd_ready=%b PSEL=%b, required ready only when idle", bus.cmd_ready, bus.PSEL);
            end
            exp_en = (bus.PSEL != '0) && (prev_psel != '0);
            n_cmp++;
            if (bus.PENABLE !== exp_en) begin
                n_bad++;
                $display("FAIL penable_phase: PENABLE=%b, required %b (PSEL=%b prev=%b)", bus.PENABLE, exp_en, bus.PSEL, prev_psel);
            end
            if (bus.PSEL != '0) begin
                exp_sel = '0;
                exp_sel[cur_idx] = 1'b1;
                n_cmp++;
                if (bus.PSEL !== exp_sel) begin
                    n_bad++;
                    $display("FAIL psel_onehot: PSEL=%b, required %b", bus.PSEL, exp_sel);
                end
                n_cmp++;
                if (bus.PADDR !== cur_addr || bus.PWRITE !== cur_write || bus.PWDATA !== cur_wdata) begin
                    n_bad++;
                    $display("FAIL bus_stable: PADDR=%h PWRITE=%b PWDATA=%h, required %h %b %h",
                             bus.PADDR, bus.PWRITE, bus.PWDATA, cur_addr, cur_write, cur_wdata);
                end
                if (bus.PENABLE) acc_cycles++;
            end
            prev_psel = bus.PSEL;
        end
    end

    task automatic set_slave(input int i, input int w, input logic er, input logic early, input logic [DW-1:0] rd);
        wait_cfg[i]  = w;
        err_cfg[i]   = er;
        early_cfg[i] = early;
        rdata_cfg[i] = rd;
    endtask

    task automatic send_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                            input logic exp_err, input logic [DW-1:0] exp_rd, input logic hold);
        int guard;
        rsp_t e;
        guard = 0;
        @(negedge PCLK);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wd;
        while (!bus.cmd_ready && guard < 100) begin
            @(negedge PCLK);
            guard++;
        end
        n_cmp++;
        if (!bus.cmd_ready) begin
            n_bad++;
            $display("FAIL cmd_accept: cmd_ready=%b, required 1 within 100 cycles", bus.cmd_ready);
            bus.cmd_valid = 1'b0;
            return;
        end
        e.err   = exp_err;
        e.rdata = exp_rd;
        exp_q.push_back(e);
        cur_addr  = addr;
        cur_write = wr;
        cur_wdata = wd;
        cur_idx   = int'(addr[SEL_LSB +: $clog2(NS)]);
        @(posedge PCLK);
        #1;
        last_acc_cyc = cyc;
        if (!hold) bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || bus.PSEL != '0) && guard < budget) begin
            @(negedge PCLK);
            guard++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL rsp_wait: %0d responses outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        for (int i = 0; i < NS; i++) set_slave(i, 0, 1'b0, 1'b0, DW'(32'hBAD0_0000 + i));
        PRESET = 1'b1;
        @(negedge PCLK);
        n_cmp++;
        if (bus.PSEL !== '0 || bus.PENABLE !== 1'b0 || bus.PADDR !== '0 || bus.PWRITE !== 1'b0 || bus.PWDATA !== '0) begin
            n_bad++;
            $display("FAIL reset_bus: PSEL=%b PENABLE=%b PADDR=%h PWRITE=%b PWDATA=%h, required all 0",
                     bus.PSEL, bus.PENABLE, bus.PADDR, bus.PWRITE, bus.PWDATA);
        end
        n_cmp++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== '0 || bus.rsp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_rsp: rsp_valid=%b rsp_rdata=%h rsp_err=%b, required 0", bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
        end
        n_cmp++;
        if (bus.cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready: cmd_ready=%b, required 1", bus.cmd_ready);
        end
        PRESET = 1'b0;
    endtask

    task automatic test_write();
        set_slave(1, 1, 1'b0, 1'b0, 32'hA1A1_A1A1);
        acc_cycles = 0;
        send_cmd(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
        wait_done(100);
        n_cmp++;
        if (acc_cycles != 2) begin
            n_bad++;
            $display("FAIL write_access_cycles: %0d, required 2", acc_cycles);
        end
        n_cmp++;
        if (last_rsp_cyc - last_acc_cyc != 3) begin
            n_bad++;
            $display("FAIL write_latency: %0d edges, required 3", last_rsp_cyc - last_acc_cyc);
        end
    endtask

    task automatic test_read();
        set_slave(3, 2, 1'b0, 1'b0, 32'h1234_5678);
        acc_cycles = 0;
        send_cmd(1'b0, 32'h0000_3008, 32'h5555_AAAA, 1'b0, 32'h1234_5678, 1'b0);
        wait_done(100);
        n_cmp++;
        if (acc_cycles != 3) begin
            n_bad++;
            $display("FAIL read_access_cycles: %0d, required 3", acc_cycles);
        end
        repeat (2) @(negedge PCLK);
        n_cmp++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h1234_5678) begin
            n_bad++;
            $display("FAIL read_hold: rsp_valid=%b rsp_rdata=%h, required 0 and 12345678", bus.rsp_valid, bus.rsp_rdata);
        end
    endtask

    task automatic test_slverr();
        // PREADY already high in SETUP must not shorten the transfer.
        set_slave(2, 0, 1'b1, 1'b1, 32'hCAFE_F00D);
        acc_cycles = 0;
        send_cmd(1'b0, 32'h0000_2000, 32'h0, 1'b1, 32'h0, 1'b0);
        wait_done(100);
        n_cmp++;
        if (acc_cycles != 1) begin
            n_bad++;
            $display("FAIL slverr_access_cycles: %0d, required 1", acc_cycles);
        end
        set_slave(2, 0, 1'b0, 1'b0, 32'hCAFE_F00D);
    endtask

    task automatic test_timeout();
        int waits [3];
        waits = '{1000, TO - 1, TO};
        for (int k = 0; k < 3; k++) begin
            logic to_hit;
            to_hit = (waits[k] >= TO);
            set_slave(0, waits[k], 1'b0, 1'b0, 32'h0F0F_0F0F);
            acc_cycles = 0;
            send_cmd(1'b0, 32'h0000_0010, 32'h0, to_hit, to_hit ? 32'h0 : 32'h0F0F_0F0F, 1'b0);
            wait_done(100);
            n_cmp++;
            if (acc_cycles != TO) begin
                n_bad++;
                $display("FAIL timeout_access_cycles[%0d]: %0d, required %0d", k, acc_cycles, TO);
            end
        end
        set_slave(0, 0, 1'b0, 1'b0, 32'h0F0F_0F0F);
        acc_cycles = 0;
        send_cmd(1'b1, 32'h0000_0020, 32'h7777_0000, 1'b0, 32'h0, 1'b0);
        wait_done(100);
        n_cmp++;
        if (acc_cycles != 1) begin
            n_bad++;
            $display("FAIL after_timeout_access_cycles: %0d, required 1", acc_cycles);
        end
    endtask

    task automatic test_back_to_back();
        int acc [4];
        int base;
        for (int i = 0; i < NS; i++) set_slave(i, 0, 1'b0, 1'b0, DW'(32'h1000_0000 * (i + 1) + i));
        base = rsp_count;
        send_cmd(1'b0, 32'h0000_0100, 32'h0,          1'b0, 32'h1000_0000, 1'b1); acc[0] = last_acc_cyc;
        send_cmd(1'b1, 32'h0000_1104, 32'h1111_2222, 1'b0, 32'h0,         1'b1); acc[1] = last_acc_cyc;
        send_cmd(1'b0, 32'h0000_2108, 32'h0,          1'b0, 32'h3000_0002, 1'b1); acc[2] = last_acc_cyc;
        send_cmd(1'b1, 32'h0000_310C, 32'h3333_4444, 1'b0, 32'h0,         1'b0); acc[3] = last_acc_cyc;
        wait_done(100);
        for (int k = 1; k < 4; k++) begin
            n_cmp++;
            if (acc[k] - acc[k-1] != 3) begin
                n_bad++;
                $display("FAIL b2b_spacing[%0d]: %0d edges, required 3", k, acc[k] - acc[k-1]);
            end
        end
        n_cmp++;
        if (rsp_count - base != 4) begin
            n_bad++;
            $display("FAIL b2b_rsp_count: %0d, required 4", rsp_count - base);
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        set_slave(0, 1000, 1'b0, 1'b0, 32'h0F0F_0F0F);
        send_cmd(1'b0, 32'h0000_0040, 32'h0, 1'b0, 32'h0, 1'b0);
        guard = 0;
        while (!bus.PENABLE && guard < 20) begin
            @(negedge PCLK);
            guard++;
        end
        n_cmp++;
        if (!bus.PENABLE) begin
            n_bad++;
            $display("FAIL reset_mid_access: PENABLE=%b, required 1 within 20 cycles", bus.PENABLE);
        end
        @(negedge PCLK);
        #2;
        exp_q.delete();
        PRESET = 1'b1;
        #1;
        n_cmp++;
        if (bus.PSEL !== '0 || bus.PENABLE !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_bus: PSEL=%b PENABLE=%b cmd_ready=%b, required 0 0 1", bus.PSEL, bus.PENABLE, bus.cmd_ready);
        end
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;
        set_slave(0, 0, 1'b0, 1'b0, 32'h0F0F_0F0F);
        acc_cycles = 0;
        send_cmd(1'b0, 32'h0000_0080, 32'h0, 1'b0, 32'h0F0F_0F0F, 1'b0);
        wait_done(100);
        n_cmp++;
        if (acc_cycles != 1) begin
            n_bad++;
            $display("FAIL reset_mid_next: %0d access cycles, required 1", acc_cycles);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_slverr();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(negedge PCLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
